// File: rtl/scmp_mem_arbiter_if.sv
// Debug/loader port of the SC/MP board RAM arbiter.
// The master side is the requester; the arbiter is the slave.
interface scmp_mem_arbiter_if;
   logic        dbg_req;
   logic        dbg_we;
   logic [15:0] dbg_addr;
   logic [7:0]  dbg_wdata;
   logic        dbg_ack;
   logic [7:0]  dbg_rdata;
   logic        dbg_starved;

   modport master (
      output dbg_req, dbg_we, dbg_addr, dbg_wdata,
      input  dbg_ack, dbg_rdata, dbg_starved
   );

   modport slave (
      input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
      output dbg_ack, dbg_rdata, dbg_starved
   );
endinterface

// File: rtl/scmp_mem_arbiter.sv
// SC/MP board RAM arbiter: CPU first, debug port in quiet bus gaps.
// Define SCMP_ARB_ROM_WP_EN to drop CPU writes into the ROM window.
module scmp_mem_arbiter #(
   parameter int          QUIET_CYCLES = 2,
   parameter int          MAX_WAIT     = 1023,
   parameter logic [15:0] ROM_BASE     = 16'h7800,
   parameter logic [15:0] ROM_TOP      = 16'h7FFF
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cpu_rd_n,
   input  logic                cpu_wr_n,
   input  logic [15:0]         cpu_addr,
   input  logic [7:0]          cpu_dout,
   output logic [7:0]          cpu_din,
   scmp_mem_arbiter_if.slave   dbg,
   output logic [15:0]         mem_addr,
   output logic                mem_we,
   output logic [7:0]          mem_wdata,
   input  logic [7:0]          mem_rdata
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] WAIT  = 3'd1;
   localparam logic [2:0] ISSUE = 3'd2;
   localparam logic [2:0] CAPT  = 3'd3;
   localparam logic [2:0] ACK   = 3'd4;

   localparam logic [3:0] QMAX = 4'(QUIET_CYCLES);
   localparam logic [9:0] WMAX = 10'(MAX_WAIT);

`ifdef SCMP_ARB_ROM_WP_EN
   localparam bit WP_EN = 1'b1;
`else
   localparam bit WP_EN = 1'b0;
`endif

   logic [2:0] state, state_nx;
   logic [3:0] quiet_cnt;
   logic [9:0] wait_cnt;
   logic [7:0] rdata_q;
   logic       starved_q;
   logic       cpu_act;
   logic       quiet;
   logic       in_rom;
   logic       cpu_prot;

   assign cpu_act  = !cpu_rd_n || !cpu_wr_n;
   assign quiet    = (quiet_cnt == QMAX);
   assign in_rom   = (cpu_addr >= ROM_BASE) && (cpu_addr <= ROM_TOP);
   assign cpu_prot = WP_EN && in_rom;

   assign cpu_din         = mem_rdata;
   assign dbg.dbg_ack     = (state == ACK);
   assign dbg.dbg_rdata   = rdata_q;
   assign dbg.dbg_starved = starved_q;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:
            if (dbg.dbg_req)
               state_nx = (quiet && !cpu_act) ? ISSUE : WAIT;
         WAIT:
            if (quiet && !cpu_act) state_nx = ISSUE;
         ISSUE:
            if (cpu_act)         state_nx = WAIT;
            else if (dbg.dbg_we) state_nx = ACK;
            else                 state_nx = CAPT;
         CAPT:    state_nx = ACK;
         ACK:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // A CPU strobe always steals the cycle, even from an ISSUE slot.
   always_comb begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_dout;
      mem_we    = 1'b0;
      if (cpu_act) begin
         mem_we = !cpu_wr_n && !cpu_prot;
      end else if (state == ISSUE) begin
         mem_addr  = dbg.dbg_addr;
         mem_wdata = dbg.dbg_wdata;
         mem_we    = dbg.dbg_we;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         quiet_cnt <= '0;
         wait_cnt  <= '0;
         rdata_q   <= 8'h00;
         starved_q <= 1'b0;
      end else begin
         state <= state_nx;

         if (cpu_act)        quiet_cnt <= '0;
         else if (!quiet)    quiet_cnt <= quiet_cnt + 4'd1;

         unique case (state)
            IDLE, ACK:   wait_cnt <= '0;
            WAIT, ISSUE:
               if (wait_cnt != '1) wait_cnt <= wait_cnt + 10'd1;
            default:     wait_cnt <= wait_cnt;
         endcase

         if (state == CAPT) rdata_q <= mem_rdata;

         // Starvation drops together with the ack pulse.
         if (state_nx == ACK || state_nx == IDLE)
            starved_q <= 1'b0;
         else
            starved_q <= (wait_cnt >= WMAX);
      end
   end

endmodule
